fir_i2s_tx: RTL

FIR_I2S_TX -- requirements
Module: fir_i2s_tx

---
 rtl/fir_i2s_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fir_i2s_tx.sv
// fir_i2s_tx: mono I2S transmitter for 32-bit filtered samples.
//
// Converts each accepted 32-bit sample to a 24-bit word and sends it in both
// the left and right halves of a 64-bit-clock I2S frame. A one-entry holding
// register decouples the sample producer from the frame timing. If no new
// sample is present at frame start, the previous word is repeated and an
// underrun is flagged and counted.
//
// Optional build macro: FIR_I2S_TX_SATURATE_EN
//   defined   -> out-of-range samples clamp to 24'h7FFFFF / 24'h800000
//   undefined -> the 24-bit window is taken as is (wrap-around truncation)
//
// Parameters:
//   CLK_DIV  clk cycles per bclk half-period (2..255)
//   SHIFT    LSB index in din_i of the transmitted 24-bit word (0..8)
//
// Ports:
//   clk_i           system clock, rising edge
//   reset_ni        synchronous active-low reset
//   din_i           signed 32-bit sample
//   din_valid_i     din_i holds a new sample
//   din_ready_o     holding register is empty and can take a sample
//   bclk_o          I2S bit clock
//   lrclk_o         I2S word select (0 = left, 1 = right)
//   sdata_o         I2S serial data, changes on bclk falling edges
//   underrun_o      one-clk pulse when a frame starts without a new sample
//   underrun_cnt_o  saturating underrun count
module fir_i2s_tx #(
    parameter int CLK_DIV = 4,
    parameter int SHIFT   = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] din_i,
    input  logic        din_valid_i,
    output logic        din_ready_o,
    output logic        bclk_o,
    output logic        lrclk_o,
    output logic        sdata_o,
    output logic        underrun_o,
    output logic [7:0]  underrun_cnt_o
);
    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    logic [7:0]  div_q, div_d;
    logic        bclk_q, bclk_d;
    logic [5:0]  bit_q, bit_d;
    logic        started_q, started_d;
    logic        lrclk_q, lrclk_d;
    logic        sdata_q, sdata_d;
    logic [23:0] sh_q, sh_d;
    logic [23:0] word_q, word_d;
    logic [23:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        underrun_q, underrun_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wrap, fall, frame_start, accept;
    logic [4:0]  pos;
    logic [23:0] conv_w, next_word;
    logic        unused_din;

    assign unused_din = ^din_i;

`ifdef FIR_I2S_TX_SATURATE_EN
    // The window fits only if every bit above it repeats the sign bit.
    logic ovf;
    assign ovf    = !((&din_i[31:SHIFT+23]) || !(|din_i[31:SHIFT+23]));
    assign conv_w = ovf ? (din_i[31] ? 24'h800000 : 24'h7FFFFF) : din_i[SHIFT+23:SHIFT];
`else
    assign conv_w = din_i[SHIFT+23:SHIFT];
`endif

    always_comb begin
        wrap        = div_q == DIV_MAX;
        fall        = wrap && bclk_q;
        // started_q makes the first falling edge after reset a frame start
        // even though the bit counter was cleared to 0 rather than 63.
        frame_start = fall && (bit_q == 6'd63 || !started_q);
        accept      = din_valid_i && !hold_full_q;
        div_d       = wrap ? 8'd0 : div_q + 8'd1;
        bclk_d      = bclk_q ^ wrap;
        bit_d       = frame_start ? 6'd0 : (fall ? bit_q + 6'd1 : bit_q);
        started_d   = started_q || frame_start;
        lrclk_d     = fall ? bit_d[5] : lrclk_q;
        next_word   = (frame_start && hold_full_q) ? hold_q : word_q;
        word_d      = next_word;
        // Slot 0 of each half is the I2S delay bit; data occupies slots 1..24.
        pos         = bit_d[4:0];
        sh_d        = !fall ? sh_q : (pos == 5'd0 ? next_word : (pos <= 5'd24 ? sh_q << 1 : sh_q));
        sdata_d     = !fall ? sdata_q : (pos != 5'd0 && pos <= 5'd24 && sh_q[23]);
        hold_d      = accept ? conv_w : hold_q;
        hold_full_d = accept || (hold_full_q && !frame_start);
        underrun_d  = frame_start && !hold_full_q;
        cnt_d       = (underrun_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            div_q       <= 8'd0;
            bclk_q      <= 1'b0;
            bit_q       <= 6'd0;
            started_q   <= 1'b0;
            lrclk_q     <= 1'b1;
            sdata_q     <= 1'b0;
            sh_q        <= 24'd0;
            word_q      <= 24'd0;
            hold_q      <= 24'd0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            bit_q       <= bit_d;
            started_q   <= started_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            sh_q        <= sh_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            cnt_q       <= cnt_d;
        end
    end

    assign din_ready_o    = !hold_full_q;
    assign bclk_o         = bclk_q;
    assign lrclk_o        = lrclk_q;
    assign sdata_o        = sdata_q;
    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = cnt_q;
endmodule
